// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch stage: widths, the NOP encoding,
// the fetch FSM state type and the default reset PC.
package riscv_pkg;

  localparam int XLEN = 64;
  localparam int ILEN = 32;

  // addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } fstate_e;

endpackage

// File: rtl/riscv_fetchq.sv
// Fetch queue: small synchronous FIFO of {pc, inst} pairs.
// The head entry is read straight out of the storage registers so the
// fetch stage outputs never pass through combinational logic from inputs.
module riscv_fetchq
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] push_pc,
  input  logic [ILEN-1:0] push_inst,
  output logic [XLEN-1:0] head_pc,
  output logic [ILEN-1:0] head_inst,
  output logic            full,
  output logic            empty,
  output logic [CW-1:0]   count
);

  logic [XLEN+ILEN-1:0] store [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  assign {head_pc, head_inst} = store[rd_ptr];

  // Entry storage; no reset needed, occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      store[wr_ptr] <= {push_pc, push_inst};
    end
  end

  // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/riscv_fstage.sv
// RISC-V fetch stage: issues in-order instruction-memory requests, tracks
// outstanding responses, buffers returned words in a small queue and
// presents them to decode. Redirects discard stale in-flight responses
// by counting them down in the DRAIN state.
module riscv_fstage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int              QDEPTH   = 2
) (
  input  logic            i_riscv_clk,
  input  logic            i_riscv_rst,
  input  logic            i_riscv_fstage_stall,
  input  logic            i_riscv_fstage_flush,
  input  logic [XLEN-1:0] i_riscv_fstage_redirpc,
  output logic            o_riscv_fstage_imem_req,
  output logic [XLEN-1:0] o_riscv_fstage_imem_addr,
  input  logic            i_riscv_fstage_imem_gnt,
  input  logic            i_riscv_fstage_imem_rvalid,
  input  logic [ILEN-1:0] i_riscv_fstage_imem_rdata,
  output logic            o_riscv_fstage_valid,
  output logic [ILEN-1:0] o_riscv_fstage_inst,
  output logic [XLEN-1:0] o_riscv_fstage_pc,
  output logic [XLEN-1:0] o_riscv_fstage_pcplus4
);

  localparam int CW = $clog2(QDEPTH + 1);

  fstate_e         state;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;     // PC belonging to the next live response
  logic [CW-1:0]   outst;
  logic [CW-1:0]   drop;
  logic [CW-1:0]   drop_after;
  logic [CW-1:0]   drop_next;
  logic [CW-1:0]   q_count;
  logic [CW:0]     inflight;
  logic            q_full;
  logic            q_empty;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_inst;
  logic            granted;
  logic            drop_hit;
  logic            live_rsp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] redir_aligned;

  // Requests depend only on registered state, so req/addr stay put until granted.
  assign inflight = {1'b0, outst} + {1'b0, q_count};
  assign o_riscv_fstage_imem_req  = (state == FETCH) && !q_full && (inflight < (CW+1)'(QDEPTH));
  assign o_riscv_fstage_imem_addr = fetch_pc;

  assign granted       = o_riscv_fstage_imem_req & i_riscv_fstage_imem_gnt;
  assign drop_hit      = i_riscv_fstage_imem_rvalid & (drop != '0);
  assign live_rsp      = i_riscv_fstage_imem_rvalid & (drop == '0) & (state != IDLE);
  assign push          = live_rsp & ~i_riscv_fstage_flush;
  assign pop           = o_riscv_fstage_valid & ~i_riscv_fstage_stall;
  assign redir_aligned = i_riscv_fstage_redirpc & ~64'd3;
  assign drop_after    = drop - CW'(drop_hit);

  // On a redirect every still-live request (incl. one granted now, minus a response
  // returning now, which is simply discarded) becomes a stale one to drop.
  always_comb begin
    drop_next = drop_after;
    if (i_riscv_fstage_flush) begin
      drop_next = drop_after + outst + CW'(granted) - CW'(live_rsp);
    end
  end

  // Fetch FSM, fetch/response PCs and the outstanding/drop counters.
  always_ff @(posedge i_riscv_clk or posedge i_riscv_rst) begin
    if (i_riscv_rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      outst    <= '0;
      drop     <= '0;
    end else begin
      drop <= drop_next;
      if (state == IDLE) begin
        state <= FETCH;
      end else begin
        state <= (drop_next != '0) ? DRAIN : FETCH;
      end
      if (i_riscv_fstage_flush) begin
        fetch_pc <= redir_aligned;
        resp_pc  <= redir_aligned;
        outst    <= '0;
      end else begin
        if (granted) fetch_pc <= fetch_pc + 64'd4;
        if (push)    resp_pc  <= resp_pc + 64'd4;
        outst <= outst + CW'(granted) - CW'(push);
      end
    end
  end

  riscv_fetchq #(
    .DEPTH(QDEPTH)
  ) u_fetchq (
    .clk       (i_riscv_clk),
    .rst       (i_riscv_rst),
    .push      (push),
    .pop       (pop),
    .clear     (i_riscv_fstage_flush),
    .push_pc   (resp_pc),
    .push_inst (i_riscv_fstage_imem_rdata),
    .head_pc   (head_pc),
    .head_inst (head_inst),
    .full      (q_full),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign o_riscv_fstage_valid   = ~q_empty;
  assign o_riscv_fstage_inst    = o_riscv_fstage_valid ? head_inst : NOP;
  assign o_riscv_fstage_pc      = o_riscv_fstage_valid ? head_pc : '0;
  assign o_riscv_fstage_pcplus4 = o_riscv_fstage_pc + 64'd4;

endmodule

// File: tb/tb_riscv_fstage.sv
// Bench for riscv_fstage: an in-order memory with random grant and latency,
// and a reference model of the instruction stream (next fetch address and
// next expected decode PC, both restarting at the redirect target).
module tb_riscv_fstage;
  import riscv_pkg::*;

  localparam int          QD  = 4;
  localparam logic [63:0] RPC = 64'h0;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [63:0] redirpc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  logic        valid;
  logic [31:0] inst;
  logic [63:0] pc;
  logic [63:0] pcplus4;

  typedef struct {
    logic [63:0] addr;
    int          ready;
  } mreq_t;

  mreq_t       memq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          npop = 0;
  int          first_gnt = -1;
  int          gnt_pct = 100;
  int          lat_lo = 1;
  int          lat_hi = 1;
  logic [63:0] exp_pc = RPC;
  logic [63:0] exp_fetch = RPC;
  logic        hold_prev = 0;
  logic [63:0] hold_pc;
  logic [31:0] hold_inst;
  logic        flush_prev = 0;
  logic        wait_prev = 0;
  logic [63:0] wait_addr;

  riscv_fstage #(.RESET_PC(RPC), .QDEPTH(QD)) dut (
    .i_riscv_clk                (clk),
    .i_riscv_rst                (rst),
    .i_riscv_fstage_stall       (stall),
    .i_riscv_fstage_flush       (flush),
    .i_riscv_fstage_redirpc     (redirpc),
    .o_riscv_fstage_imem_req    (imem_req),
    .o_riscv_fstage_imem_addr   (imem_addr),
    .i_riscv_fstage_imem_gnt    (gnt),
    .i_riscv_fstage_imem_rvalid (rvalid),
    .i_riscv_fstage_imem_rdata  (rdata),
    .o_riscv_fstage_valid       (valid),
    .o_riscv_fstage_inst        (inst),
    .o_riscv_fstage_pc          (pc),
    .o_riscv_fstage_pcplus4     (pcplus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "time limit");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic reset_checks();
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_addr", imem_addr, RPC);
    check_eq("rst_valid", valid, 1'b0);
    check_eq("rst_inst", inst, NOP);
    check_eq("rst_pc", pc, 64'h0);
    check_eq("rst_pcplus4", pcplus4, 64'h4);
  endtask

  // One cycle: check outputs, drive inputs, advance the model, step to next negedge.
  task automatic tick(input logic fl, input logic [63:0] tgt, input logic st);
    logic        do_gnt;
    logic        do_rv;
    logic [31:0] rd;
    logic [63:0] inflight;
    if (!valid) begin
      check_eq("nop_when_idle", inst, NOP);
    end else begin
      check_eq("inst_matches_pc", inst, mem_word(pc));
      check_eq("pcplus4", pcplus4, pc + 64'd4);
    end
    if (hold_prev) begin
      check_eq("stall_hold_valid", valid, 1'b1);
      check_eq("stall_hold_pc", pc, hold_pc);
      check_eq("stall_hold_inst", inst, hold_inst);
    end
    if (flush_prev) check_eq("valid_after_flush", valid, 1'b0);
    if (wait_prev) begin
      check_eq("req_held", imem_req, 1'b1);
      check_eq("addr_held", imem_addr, wait_addr);
    end

    do_gnt = ($urandom_range(0, 99) < gnt_pct);
    do_rv  = (memq.size() > 0) && (memq[0].ready <= cyc);
    rd     = do_rv ? mem_word(memq[0].addr) : $urandom;
    if (do_rv) void'(memq.pop_front());
    gnt     = do_gnt;
    rvalid  = do_rv;
    rdata   = rd;
    stall   = st;
    flush   = fl;
    redirpc = tgt;

    if (valid && !st && !fl) begin
      check_eq("pop_pc", pc, exp_pc);
      exp_pc += 64'd4;
      npop++;
    end
    if (imem_req && do_gnt) begin
      check_eq("fetch_addr", imem_addr, exp_fetch);
      memq.push_back('{imem_addr, cyc + int'($urandom_range(lat_lo, lat_hi))});
      exp_fetch += 64'd4;
      if (first_gnt < 0) first_gnt = cyc;
    end
    if (fl) begin
      exp_pc    = tgt & ~64'd3;
      exp_fetch = tgt & ~64'd3;
    end
    inflight = (exp_fetch - exp_pc) >> 2;
    if (inflight > QD) check_eq("inflight_bound", inflight, QD);

    hold_prev  = valid && st && !fl;
    hold_pc    = pc;
    hold_inst  = inst;
    flush_prev = fl;
    wait_prev  = imem_req && !do_gnt && !fl;
    wait_addr  = imem_addr;

    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic model_reset();
    memq.delete();
    exp_pc     = RPC;
    exp_fetch  = RPC;
    hold_prev  = 0;
    flush_prev = 0;
    wait_prev  = 0;
  endtask

  initial begin
    int          n;
    logic        found;
    logic [63:0] t;
    rst = 1'b1; stall = 0; flush = 0; redirpc = '0; gnt = 0; rvalid = 0; rdata = '0;
    repeat (3) @(negedge clk);
    #1 reset_checks();

    // Startup: 1-cycle memory, always granting, no stall
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("idle_no_req", imem_req, 1'b0);
    tick(0, '0, 0);
    check_eq("fetch_req", imem_req, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (first_gnt >= 0 && cyc == first_gnt + 1) check_eq("first_valid_early", valid, 1'b0);
      if (first_gnt >= 0 && cyc == first_gnt + 2) check_eq("first_pc", pc, RPC);
      if (first_gnt >= 0 && cyc >= first_gnt + 2 && cyc <= first_gnt + 5)
        check_eq("stream_valid", valid, 1'b1);
      if (valid && pc == 64'h8) break;
      tick(0, '0, 0);
    end

    // Stall while 0x8 is presented until the queue fills
    found = 0;
    for (n = 0; n < 20 && !found; n++) begin
      if (valid && pc == 64'h8) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("see_pc8", found, 1'b1);
    repeat (10) tick(0, '0, 1);
    check_eq("stall_pc", pc, 64'h8);
    check_eq("stall_req_low", imem_req, 1'b0);
    check_eq("stall_fill", (exp_fetch - exp_pc) >> 2, QD);
    repeat (6) tick(0, '0, 0);

    // Flush to 0x100 with two outstanding requests
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (n = 0; n < 50 && !found; n++) begin
      if (memq.size() == 2) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("flush2_setup", found, 1'b1);
    tick(1, 64'h100, 0);
    repeat (20) tick(0, '0, 0);

    // Flush coinciding with rvalid and gnt, misaligned target
    lat_lo = 1; lat_hi = 1;
    found = 0;
    for (n = 0; n < 50 && !found; n++) begin
      if (imem_req && memq.size() > 0 && memq[0].ready <= cyc) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("flush3_setup", found, 1'b1);
    tick(1, 64'h203, 0);
    found = 0;
    for (n = 0; n < 10 && !found; n++) begin
      if (imem_req) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("redir_req_seen", found, 1'b1);
    check_eq("redir_addr", imem_addr, 64'h200);
    repeat (15) tick(0, '0, 0);

    // Second redirect while draining
    lat_lo = 3; lat_hi = 3;
    found = 0;
    for (n = 0; n < 50 && !found; n++) begin
      if (memq.size() >= 2) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("flush4_setup", found, 1'b1);
    tick(1, 64'h300, 0);
    tick(1, 64'h400, 0);
    n = npop;
    repeat (30) tick(0, '0, 0);
    check_eq("drain_progress", npop > n, 1'b1);

    // Random traffic
    gnt_pct = 70; lat_lo = 1; lat_hi = 4;
    n = npop;
    for (int i = 0; i < 2500; i++) begin
      t = {$urandom, $urandom};
      if ($urandom_range(0, 7) == 0) t = t | 64'hFFFF_FFFF_FFFF_FF00;
      tick($urandom_range(0, 99) < 3, t, $urandom_range(0, 99) < 30);
    end
    check_eq("random_progress", (npop - n) > 200, 1'b1);

    // Reset while an instruction is presented and a request is in flight
    gnt_pct = 50; lat_lo = 2; lat_hi = 3;
    found = 0;
    for (n = 0; n < 200 && !found; n++) begin
      if (valid && memq.size() == 1) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("reset_setup", found, 1'b1);
    #2 rst = 1'b1; gnt = 0; rvalid = 0; flush = 0; stall = 0;
    #1 reset_checks();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gnt_pct = 100; lat_lo = 1; lat_hi = 2;
    found = 0;
    for (n = 0; n < 10 && !found; n++) begin
      if (imem_req) found = 1;
      else tick(0, '0, 0);
    end
    check_eq("restart_req_seen", found, 1'b1);
    check_eq("restart_addr", imem_addr, RPC);
    n = npop;
    repeat (30) tick(0, '0, 0);
    check_eq("restart_progress", npop > n, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_fstage.md
RISCV_FSTAGE -- requirements
Module: riscv_fstage

Interface
REQ-001 Parameter: RESET_PC, 64'h0, first fetch address after reset.
REQ-002 Parameter: QDEPTH, 2, fetch-queue entries; legal values 2 or 4.
REQ-003 Port: i_riscv_clk  in  1  sole clock, rising edge.
REQ-004 Port: i_riscv_rst  in  1  reset, asynchronous, active-high.
REQ-005 Port: i_riscv_fstage_stall  in  1  decode not accepting the presented instruction.
REQ-006 Port: i_riscv_fstage_flush  in  1  branch/jump redirect from execute.
REQ-007 Port: i_riscv_fstage_redirpc  in  64  redirect target.
REQ-008 Port: o_riscv_fstage_imem_req  out  1  instruction-memory request.
REQ-009 Port: o_riscv_fstage_imem_addr  out  64  request address.
REQ-010 Port: i_riscv_fstage_imem_gnt  in  1  request accepted this cycle.
REQ-011 Port: i_riscv_fstage_imem_rvalid  in  1  response valid; responses return in order, at least 1 cycle after grant.
REQ-012 Port: i_riscv_fstage_imem_rdata  in  32  response instruction.
REQ-013 Port: o_riscv_fstage_valid  out  1  instruction presented to decode.
REQ-014 Port: o_riscv_fstage_inst  out  32  instruction word; NOP (32'h00000013) when valid is low.
REQ-015 Port: o_riscv_fstage_pc  out  64  PC of the presented instruction.
REQ-016 Port: o_riscv_fstage_pcplus4  out  64  o_riscv_fstage_pc + 4.

Function
REQ-017 FSM states: IDLE, FETCH, DRAIN.
REQ-018 IDLE is entered on reset; IDLE moves to FETCH on the first clock edge after reset deassertion; no request is issued in IDLE.
REQ-019 FETCH: imem_req is asserted when outstanding + queue occupancy < QDEPTH; imem_addr = fetch PC; on req & gnt, fetch PC += 4 and outstanding += 1.
REQ-020 imem_req and imem_addr are held stable until gnt.
REQ-021 On rvalid with no pending drop, {pc, rdata} is pushed into the queue and outstanding -= 1.
REQ-022 Queue head drives valid/inst/pc/pcplus4 from registered storage; a response returned in cycle N is visible at the outputs in cycle N+1.
REQ-023 Pop occurs when valid & !stall; an instruction stays presented, unchanged, while stall is high.
REQ-024 Flush, regardless of stall: the queue is emptied, fetch PC := {redirpc[63:2], 2'b00}, drop count := outstanding (including any request granted in the same cycle), outstanding := 0; valid is low in the following cycle.
REQ-025 After a flush with drop count > 0, the FSM enters DRAIN; each rvalid decrements the drop count and its data is discarded; no request is issued; the FSM returns to FETCH when the count reaches 0.
REQ-026 After a flush with drop count = 0, the FSM stays in or returns to FETCH.
REQ-027 rvalid in the same cycle as a flush is discarded and is not counted in the drop count.
REQ-028 A flush during DRAIN adds the current outstanding count to the drop count and reloads the fetch PC; the last redirect wins.
REQ-029 The queue never overflows: when full, or when full minus outstanding, req is low.
REQ-030 Push and pop in the same cycle on a full queue are legal; occupancy is unchanged.
REQ-031 The fetch PC wraps modulo 2^64 with no exception.

Reset
REQ-032 Asynchronous reset: state = IDLE; fetch PC = RESET_PC; queue empty; outstanding = 0; drop count = 0.
REQ-033 Output values during reset: imem_req = 0, imem_addr = RESET_PC, valid = 0, inst = NOP, pc = 0, pcplus4 = 4.
REQ-034 Reset asserted mid-transaction abandons all in-flight responses; the memory is reset together with this block.

Structure
REQ-035 The shared package riscv_pkg holds: the NOP constant, the FSM state enum, the instruction/PC width constants, and the RESET_PC default.
REQ-036 The fetch queue is the sub-module riscv_fetchq: a synchronous FIFO of {pc[63:0], inst[31:0]} with push/pop/clear/full/empty/count.
REQ-037 The drop and outstanding counters are sized to cover QDEPTH.

Verification
REQ-038 Reset release, 1-cycle memory, no stall -> requests to 0x0, 0x4, 0x8; inst from 0x0 is valid 2 cycles after the first grant, followed by one instruction per cycle.
REQ-039 Stall held 3 cycles while 0x8 is presented -> pc stays 0x8; the queue fills to QDEPTH; req drops; no instruction is lost or duplicated after release.
REQ-040 Flush to 0x100 with 2 outstanding -> the next 2 responses are discarded; the next presented pc is 0x100; valid is low the cycle after the flush.
REQ-041 Flush, rvalid and gnt in the same cycle, redirpc = 0x203 -> the response is dropped, drop count = 1, the next fetch address is 0x200.
REQ-042 Second flush to 0x400 while in DRAIN -> all stale responses are dropped; the first presented pc is 0x400.
REQ-043 Reset asserted while valid is high and 1 request is outstanding -> the outputs take the REQ-033 values immediately; after release, fetch restarts at RESET_PC.
